// File: rtl/lcd_bus_pkg.sv
// rtl/lcd_bus_pkg.sv - shared types and constants for the LCD bus arbiter
package lcd_bus_pkg;

  typedef enum logic [1:0] {P_RST, P_WAIT, IDLE, BUSY} ctl_state_t;
  typedef enum logic [1:0] {S_IDLE, SETUP, WR_L, WR_H} strobe_state_t;

  localparam int RST_LOW_DEF  = 120;
  localparam int RST_WAIT_DEF = 1440000;

  typedef struct packed {
    logic wr;
    logic rd;
    logic cs;
  } bus_ctl_t;

  localparam bus_ctl_t BUS_INACTIVE = '{wr: 1'b1, rd: 1'b1, cs: 1'b1};

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_wr_strobe.sv
// rtl/lcd_wr_strobe.sv - one-byte write cycle: setup, wr low phase, wr high phase
module lcd_wr_strobe
  import lcd_bus_pkg::*;
#(
  parameter int WR_LOW  = 2,
  parameter int WR_HIGH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       byte_rs,
  input  logic [7:0] byte_data,
  output logic [7:0] d,
  output logic       rs,
  output logic       wr,
  output logic       done
);

  localparam int CW = $clog2(max2(WR_LOW, WR_HIGH)) + 1;

  strobe_state_t   state;
  logic [CW-1:0]   cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      d     <= '0;
      rs    <= 1'b0;
      wr    <= BUS_INACTIVE.wr;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            d     <= byte_data;
            rs    <= byte_rs;
            state <= SETUP;
          end
        end
        SETUP: begin
          state <= WR_L;
          cnt   <= CW'(WR_LOW - 1);
          wr    <= 1'b0;
        end
        WR_L: begin
          if (cnt == '0) begin
            state <= WR_H;
            cnt   <= CW'(WR_HIGH - 1);
            wr    <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        WR_H: begin
          if (cnt == '0) state <= S_IDLE;
          else           cnt   <= cnt - CW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Pulses during the final high-phase cycle so the caller is back in IDLE next cycle
  assign done = (state == WR_H) && (cnt == '0);

endmodule

// File: rtl/lcd_bus_arbiter.sv
// rtl/lcd_bus_arbiter.sv - panel reset sequencing and round-robin burst-locked arbitration of the LCD write bus
module lcd_bus_arbiter
  import lcd_bus_pkg::*;
#(
  parameter int WR_LOW   = 2,
  parameter int WR_HIGH  = 2,
  parameter int RST_LOW  = RST_LOW_DEF,
  parameter int RST_WAIT = RST_WAIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       r0_valid,
  input  logic       r0_rs,
  input  logic [7:0] r0_data,
  input  logic       r0_last,
  output logic       r0_ready,
  input  logic       r1_valid,
  input  logic       r1_rs,
  input  logic [7:0] r1_data,
  input  logic       r1_last,
  output logic       r1_ready,
  output logic [7:0] d,
  output logic       rs,
  output logic       wr,
  output logic       rd,
  output logic       cs,
  output logic       lcd_rst,
  output logic       init_done
);

  localparam int CW = $clog2(max2(RST_LOW, RST_WAIT)) + 1;

  ctl_state_t    state;
  logic [CW-1:0] cnt;
  logic          locked;
  logic          owner;
  logic          last_gnt;
  logic          last_q;
  logic          grant0;
  logic          grant1;
  logic          start;
  logic          sel_rs;
  logic [7:0]    sel_data;
  logic          sel_last;
  logic          strobe_done;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (locked) begin
        grant0 = !owner && r0_valid;
        grant1 = owner && r1_valid;
      end else if (r0_valid && r1_valid) begin
        // last_gnt resets to 1 so that r0 wins the first contest
        grant0 = last_gnt;
        grant1 = !last_gnt;
      end else begin
        grant0 = r0_valid;
        grant1 = r1_valid;
      end
    end
  end

  assign start    = grant0 || grant1;
  assign sel_rs   = grant1 ? r1_rs   : r0_rs;
  assign sel_data = grant1 ? r1_data : r0_data;
  assign sel_last = grant1 ? r1_last : r0_last;
  assign r0_ready = grant0;
  assign r1_ready = grant1;
  assign rd       = BUS_INACTIVE.rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= P_RST;
      cnt       <= CW'(RST_LOW - 1);
      lcd_rst   <= 1'b0;
      init_done <= 1'b0;
      cs        <= BUS_INACTIVE.cs;
      locked    <= 1'b0;
      owner     <= 1'b0;
      last_gnt  <= 1'b1;
      last_q    <= 1'b0;
    end else begin
      case (state)
        P_RST: begin
          if (cnt == '0) begin
            state   <= P_WAIT;
            cnt     <= CW'(RST_WAIT - 1);
            lcd_rst <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        P_WAIT: begin
          if (cnt == '0) begin
            state     <= IDLE;
            init_done <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        IDLE: begin
          if (start) begin
            state  <= BUSY;
            cs     <= 1'b0;
            locked <= 1'b1;
            owner  <= grant1;
            last_q <= sel_last;
          end
        end
        BUSY: begin
          if (strobe_done) begin
            state <= IDLE;
            // Mid-burst bytes keep cs low so the panel sees one continuous transaction
            if (last_q) begin
              locked   <= 1'b0;
              last_gnt <= owner;
              cs       <= BUS_INACTIVE.cs;
            end
          end
        end
        default: state <= P_RST;
      endcase
    end
  end

  lcd_wr_strobe #(
    .WR_LOW  (WR_LOW),
    .WR_HIGH (WR_HIGH)
  ) u_strobe (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .byte_rs   (sel_rs),
    .byte_data (sel_data),
    .d         (d),
    .rs        (rs),
    .wr        (wr),
    .done      (strobe_done)
  );

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb/tb_lcd_bus_arbiter.sv - directed self-checking bench for lcd_bus_arbiter
module tb_lcd_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       r0_valid = 1'b0, r0_rs = 1'b0, r0_last = 1'b0;
  logic [7:0] r0_data = 8'h00;
  logic       r1_valid = 1'b0, r1_rs = 1'b0, r1_last = 1'b0;
  logic [7:0] r1_data = 8'h00;
  logic       r0_ready, r1_ready;
  logic [7:0] d;
  logic       rs, wr, rd, cs, lcd_rst, init_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lcd_bus_arbiter #(
    .WR_LOW   (2),
    .WR_HIGH  (2),
    .RST_LOW  (4),
    .RST_WAIT (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .r0_valid  (r0_valid),
    .r0_rs     (r0_rs),
    .r0_data   (r0_data),
    .r0_last   (r0_last),
    .r0_ready  (r0_ready),
    .r1_valid  (r1_valid),
    .r1_rs     (r1_rs),
    .r1_data   (r1_data),
    .r1_last   (r1_last),
    .r1_ready  (r1_ready),
    .d         (d),
    .rs        (rs),
    .wr        (wr),
    .rd        (rd),
    .cs        (cs),
    .lcd_rst   (lcd_rst),
    .init_done (init_done)
  );

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Called at the negedge of the cycle after accept; walks SETUP, WR_L x2, WR_H x2, then the IDLE entry cycle
  task automatic byte_rest(input logic [7:0] exp_d, input logic exp_rs, input logic exp_last);
    #1;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) begin
        step();
        #1;
      end
      chk8("byte_d", d, exp_d);
      chk1("byte_rs", rs, exp_rs);
      chk1("byte_cs", cs, 1'b0);
      chk1("byte_wr", wr, (k == 2 || k == 3) ? 1'b0 : 1'b1);
      chk1("busy_r0_ready", r0_ready, 1'b0);
      chk1("busy_r1_ready", r1_ready, 1'b0);
    end
    step();
    #1;
    chk1("end_cs", cs, exp_last ? 1'b1 : 1'b0);
    chk1("end_wr", wr, 1'b1);
    chk8("end_d_hold", d, exp_d);
  endtask

  task automatic reinit();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (12) step();
    #1;
    chk1("reinit_done", init_done, 1'b1);
    chk1("reinit_lcd_rst", lcd_rst, 1'b1);
  endtask

  initial begin
    // Reset sequence with r0 already requesting
    step();
    chk8("rst_d", d, 8'h00);
    chk1("rst_rs", rs, 1'b0);
    chk1("rst_wr", wr, 1'b1);
    chk1("rst_rd", rd, 1'b1);
    chk1("rst_cs", cs, 1'b1);
    chk1("rst_lcd_rst", lcd_rst, 1'b0);
    chk1("rst_init_done", init_done, 1'b0);
    chk1("rst_r1_ready", r1_ready, 1'b0);
    rst = 1'b0;
    r0_valid = 1'b1; r0_rs = 1'b1; r0_data = 8'h5A; r0_last = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk1("prst_lcd_rst", lcd_rst, 1'b0);
      chk1("prst_ready", r0_ready, 1'b0);
      step();
      #1;
    end
    for (int i = 0; i < 8; i++) begin
      chk1("pwait_lcd_rst", lcd_rst, 1'b1);
      chk1("pwait_init", init_done, 1'b0);
      chk1("pwait_ready", r0_ready, 1'b0);
      step();
      #1;
    end
    chk1("init_rise", init_done, 1'b1);
    chk1("single_r0_ready", r0_ready, 1'b1);
    chk1("single_cs_accept", cs, 1'b1);
    step();
    r0_valid = 1'b0; r0_data = 8'hFF; r0_rs = 1'b0;
    byte_rest(8'h5A, 1'b1, 1'b1);

    // Simultaneous requests after a fresh reset: r0 first, then alternation
    reinit();
    r0_valid = 1'b1; r0_rs = 1'b0; r0_data = 8'h10; r0_last = 1'b1;
    r1_valid = 1'b1; r1_rs = 1'b1; r1_data = 8'h20; r1_last = 1'b1;
    #1;
    chk1("rr1_r0", r0_ready, 1'b1);
    chk1("rr1_r1", r1_ready, 1'b0);
    step();
    r0_data = 8'h11;
    byte_rest(8'h10, 1'b0, 1'b1);
    chk1("rr2_r0", r0_ready, 1'b0);
    chk1("rr2_r1", r1_ready, 1'b1);
    step();
    r1_data = 8'h21;
    byte_rest(8'h20, 1'b1, 1'b1);
    chk1("rr3_r0", r0_ready, 1'b1);
    chk1("rr3_r1", r1_ready, 1'b0);
    step();
    r0_valid = 1'b0;
    byte_rest(8'h11, 1'b0, 1'b1);
    chk1("rr4_r1", r1_ready, 1'b1);
    step();
    r1_valid = 1'b0;
    byte_rest(8'h21, 1'b1, 1'b1);

    // Burst lock: three r0 bytes with r1 waiting
    r0_valid = 1'b1; r0_rs = 1'b1; r0_data = 8'h01; r0_last = 1'b0;
    r1_valid = 1'b1; r1_rs = 1'b1; r1_data = 8'h30; r1_last = 1'b1;
    #1;
    chk1("burst1_r0", r0_ready, 1'b1);
    chk1("burst1_r1", r1_ready, 1'b0);
    step();
    r0_data = 8'h02;
    byte_rest(8'h01, 1'b1, 1'b0);
    chk1("burst2_r0", r0_ready, 1'b1);
    chk1("burst2_r1", r1_ready, 1'b0);
    step();
    r0_data = 8'h03; r0_last = 1'b1;
    byte_rest(8'h02, 1'b1, 1'b0);
    chk1("burst3_r0", r0_ready, 1'b1);
    chk1("burst3_r1", r1_ready, 1'b0);
    step();
    r0_valid = 1'b0;
    byte_rest(8'h03, 1'b1, 1'b1);
    chk1("after_burst_r1", r1_ready, 1'b1);
    step();
    r1_valid = 1'b0;
    byte_rest(8'h30, 1'b1, 1'b1);

    // Owner stall: r0 holds the lock with valid low while r1 requests
    r0_valid = 1'b1; r0_rs = 1'b0; r0_data = 8'h40; r0_last = 1'b0;
    #1;
    chk1("stall_accept", r0_ready, 1'b1);
    step();
    r0_valid = 1'b0;
    r1_valid = 1'b1; r1_rs = 1'b1; r1_data = 8'h50; r1_last = 1'b1;
    byte_rest(8'h40, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      chk1("stall_r1_ready", r1_ready, 1'b0);
      chk1("stall_cs", cs, 1'b0);
      chk1("stall_wr", wr, 1'b1);
      step();
      #1;
    end
    r0_valid = 1'b1; r0_data = 8'h41; r0_last = 1'b1;
    #1;
    chk1("stall_resume_r0", r0_ready, 1'b1);
    chk1("stall_resume_r1", r1_ready, 1'b0);
    step();
    r0_valid = 1'b0;
    byte_rest(8'h41, 1'b0, 1'b1);
    chk1("stall_release_r1", r1_ready, 1'b1);
    step();
    r1_valid = 1'b0;
    byte_rest(8'h50, 1'b1, 1'b1);

    // Reset during the wr low phase
    r1_valid = 1'b1; r1_rs = 1'b1; r1_data = 8'h60; r1_last = 1'b1;
    #1;
    chk1("mid_accept", r1_ready, 1'b1);
    step();
    r1_valid = 1'b0;
    step();
    #1;
    chk1("mid_wr_low", wr, 1'b0);
    rst = 1'b1;
    step();
    #1;
    chk1("mid_rst_wr", wr, 1'b1);
    chk1("mid_rst_cs", cs, 1'b1);
    chk1("mid_rst_lcd_rst", lcd_rst, 1'b0);
    chk1("mid_rst_init", init_done, 1'b0);
    chk8("mid_rst_d", d, 8'h00);
    rst = 1'b0;
    repeat (12) step();
    #1;
    chk1("mid_reinit_done", init_done, 1'b1);
    r1_valid = 1'b1; r1_rs = 1'b0; r1_data = 8'h77; r1_last = 1'b1;
    #1;
    chk1("post_rst_r1", r1_ready, 1'b1);
    chk1("post_rst_r0", r0_ready, 1'b0);
    step();
    r1_valid = 1'b0;
    byte_rest(8'h77, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
